// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------
// inst_fetch_pkg : shared constants, fetch state enum and helpers
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

package inst_fetch_pkg;

    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DROP  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------
// inst_fetch_if : instruction-memory request/response bus
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_skid_buf.sv
// ---------------------------------------------------------------------
// fetch_skid_buf : one-entry pc/inst holding slot (load/flush/pop)
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module fetch_skid_buf
    import inst_fetch_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_load,
    input  wire logic        i_flush,
    input  wire logic        i_pop,
    input  wire logic [31:0] i_pc,
    input  wire logic [31:0] i_inst,
    output logic             o_full,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_inst
);

    logic        r_full;
    logic [31:0] r_pc;
    logic [31:0] r_inst;

    // Flush beats load so a redirect always wins over a stalled capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_pc   <= 32'h0;
            r_inst <= C_NOP;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_pc   <= i_pc;
            r_inst <= i_inst;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_pc   = r_pc;
    assign o_inst = r_inst;

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------
// inst_fetch : IF stage with redirect/drop handling and IF/ID register
// Optional macro FETCH_PERF_CNT_EN adds fetch/stall performance counters.
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC
)(
    input  wire logic        clk,
    input  wire logic        rst_n,
    inst_fetch_if.master     imem,
    input  wire logic        stall_flag,
    input  wire logic        br_taken,
    input  wire logic [31:0] br_target,
    input  wire logic        trap_en,
    input  wire logic [31:0] trap_vec,
    output logic [31:0]      pc_out,
    output logic [31:0]      inst_out,
    output logic             inst_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_redir, w_redir_nxt;
    logic [31:0]  r_pc_out, w_pc_out_nxt;
    logic [31:0]  r_inst_out, w_inst_out_nxt;
    logic         r_inst_valid, w_inst_valid_nxt;

    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_skid_load, w_skid_flush, w_skid_pop, w_ifid_fire;
    logic         w_skid_full;
    logic [31:0]  w_skid_pc, w_skid_inst;

    assign w_redirect = trap_en | br_taken;
    assign w_target   = align_word(trap_en ? trap_vec : br_target);

    assign imem.imem_req  = rst_n & (r_state != ST_HOLD);
    assign imem.imem_addr = r_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_redir      <= RESET_PC;
            r_pc_out     <= RESET_PC;
            r_inst_out   <= C_NOP;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_redir      <= w_redir_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_inst_out   <= w_inst_out_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    // The pending request keeps r_pc as its address; a redirect that
    // cannot complete yet parks its target in r_redir until the memory
    // returns the stale word.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_redir_nxt = r_redir;
        case (r_state)
            ST_FETCH: begin
                if (imem.imem_ready) begin
                    if (w_redirect) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                        if (stall_flag) w_state_nxt = ST_HOLD;
                    end
                end else if (w_redirect) begin
                    w_redir_nxt = w_target;
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem.imem_ready) begin
                    w_pc_nxt    = w_redirect ? w_target : r_redir;
                    w_state_nxt = ST_FETCH;
                end else if (w_redirect) begin
                    w_redir_nxt = w_target;
                end
            end
            ST_HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_FETCH;
                end else if (!stall_flag) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        w_skid_load      = (r_state == ST_FETCH) & imem.imem_ready & stall_flag & ~w_redirect;
        w_skid_flush     = w_redirect;
        w_skid_pop       = (r_state == ST_HOLD) & ~stall_flag & ~w_redirect;
        w_ifid_fire      = 1'b0;
        w_pc_out_nxt     = r_pc_out;
        w_inst_out_nxt   = r_inst_out;
        w_inst_valid_nxt = r_inst_valid;
        if (w_redirect) begin
            w_inst_out_nxt   = C_NOP;
            w_inst_valid_nxt = 1'b0;
        end else if (!stall_flag) begin
            if ((r_state == ST_FETCH) && imem.imem_ready) begin
                w_pc_out_nxt     = r_pc;
                w_inst_out_nxt   = imem.imem_rdata;
                w_inst_valid_nxt = 1'b1;
                w_ifid_fire      = 1'b1;
            end else if (r_state == ST_HOLD) begin
                w_pc_out_nxt     = w_skid_pc;
                w_inst_out_nxt   = w_skid_inst;
                w_inst_valid_nxt = w_skid_full;
                w_ifid_fire      = w_skid_full;
            end else begin
                w_inst_out_nxt   = C_NOP;
                w_inst_valid_nxt = 1'b0;
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_flush (w_skid_flush),
        .i_pop   (w_skid_pop),
        .i_pc    (r_pc),
        .i_inst  (imem.imem_rdata),
        .o_full  (w_skid_full),
        .o_pc    (w_skid_pc),
        .o_inst  (w_skid_inst)
    );

    assign pc_out     = r_pc_out;
    assign inst_out   = r_inst_out;
    assign inst_valid = r_inst_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetch <= 32'h0;
            r_perf_stall <= 32'h0;
        end else begin
            if (w_ifid_fire) r_perf_fetch <= r_perf_fetch + 32'd1;
            if (stall_flag)  r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_ifid_fire;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------
// tb_inst_fetch : directed scenarios with an IF/ID scoreboard
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch;
    import inst_fetch_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready_drv;
    logic        stall_flag;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap_en;
    logic [31:0] trap_vec;
    wire  [31:0] pc_out;
    wire  [31:0] inst_out;
    wire         inst_valid;
`ifdef FETCH_PERF_CNT_EN
    wire  [31:0] perf_fetch_cnt;
    wire  [31:0] perf_stall_cnt;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t sb_e;
    logic m_stall, m_redir, m_rst;

    inst_fetch_if bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_ready = ready_drv;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    inst_fetch #(.RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (bus.master),
        .stall_flag (stall_flag),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .trap_en    (trap_en),
        .trap_vec   (trap_vec),
        .pc_out     (pc_out),
        .inst_out   (inst_out),
        .inst_valid (inst_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        sb_q.push_back(e);
    endtask

    // A fresh valid load into IF/ID happens only on edges without stall/redirect.
    always @(posedge clk) begin
        m_stall = stall_flag;
        m_redir = br_taken | trap_en;
        m_rst   = rst_n;
        #1;
        if (m_rst && !m_stall && !m_redir && inst_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_valid", {31'b0, inst_valid}, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check_eq("sb_pc", pc_out, sb_e.pc);
                check_eq("sb_inst", inst_out, sb_e.inst);
            end
        end
    end

    initial begin
        rst_n = 1'b0; ready_drv = 1'b1; stall_flag = 1'b0;
        br_taken = 1'b0; br_target = 32'h0; trap_en = 1'b0; trap_vec = 32'h0;
        tick(); tick();
        check_eq("rst_req", {31'b0, bus.imem_req}, 32'd0);
        check_eq("rst_pc_out", pc_out, 32'h0);
        check_eq("rst_inst", inst_out, C_NOP);
        check_eq("rst_valid", {31'b0, inst_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_req", {31'b0, bus.imem_req}, 32'd1);
        check_eq("rel_addr", bus.imem_addr, 32'h0);
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);

        // back-to-back fetches
        tick(); check_eq("seq_addr4", bus.imem_addr, 32'h4);
        tick(); check_eq("seq_addr8", bus.imem_addr, 32'h8);
        tick(); check_eq("seq_addrC", bus.imem_addr, 32'hC);
        tick(); check_eq("seq_addr10", bus.imem_addr, 32'h10);
        stall_flag = 1'b1;

        // stall captures 0x10 in the skid buffer
        tick();
        check_eq("hold_req", {31'b0, bus.imem_req}, 32'd0);
        check_eq("hold_pc_out", pc_out, 32'hC);
        check_eq("hold_valid", {31'b0, inst_valid}, 32'd1);
        check_eq("hold_addr", bus.imem_addr, 32'h14);
        tick(); check_eq("hold2_req", {31'b0, bus.imem_req}, 32'd0);
        check_eq("hold2_pc_out", pc_out, 32'hC);
        tick(); check_eq("hold3_pc_out", pc_out, 32'hC);
        stall_flag = 1'b0;
        push(32'h10);
        tick();
        check_eq("unhold_pc_out", pc_out, 32'h10);
        check_eq("unhold_req", {31'b0, bus.imem_req}, 32'd1);
        check_eq("unhold_addr", bus.imem_addr, 32'h14);
        push(32'h14); push(32'h18); push(32'h1C);
        tick(); tick(); tick();
        check_eq("pre_drop_addr", bus.imem_addr, 32'h20);

        // branch while memory is not ready: DROP
        ready_drv = 1'b0; br_taken = 1'b1; br_target = 32'h80;
        tick();
        check_eq("drop_addr", bus.imem_addr, 32'h20);
        check_eq("drop_req", {31'b0, bus.imem_req}, 32'd1);
        check_eq("drop_inst", inst_out, C_NOP);
        check_eq("drop_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("drop_pc_out", pc_out, 32'h1C);
        br_taken = 1'b0;
        tick();
        check_eq("drop2_addr", bus.imem_addr, 32'h20);
        check_eq("drop2_valid", {31'b0, inst_valid}, 32'd0);
        ready_drv = 1'b1;
        tick();
        check_eq("redir_addr", bus.imem_addr, 32'h80);
        check_eq("flush_valid", {31'b0, inst_valid}, 32'd0);
        push(32'h80);
        tick(); check_eq("br_addr84", bus.imem_addr, 32'h84);

        // trap beats branch and overrides stall
        trap_en = 1'b1; trap_vec = 32'h100; br_taken = 1'b1; br_target = 32'h80; stall_flag = 1'b1;
        tick();
        check_eq("trap_addr", bus.imem_addr, 32'h100);
        check_eq("trap_inst", inst_out, C_NOP);
        check_eq("trap_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("trap_pc_out", pc_out, 32'h80);
        trap_en = 1'b0; br_taken = 1'b0; stall_flag = 1'b0;
        push(32'h100);
        tick(); check_eq("trap_addr104", bus.imem_addr, 32'h104);

        // redirect from HOLD with unaligned target
        stall_flag = 1'b1;
        tick(); check_eq("hold_b_req", {31'b0, bus.imem_req}, 32'd0);
        br_taken = 1'b1; br_target = 32'h202;
        tick();
        check_eq("holdredir_addr", bus.imem_addr, 32'h200);
        check_eq("holdredir_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("holdredir_req", {31'b0, bus.imem_req}, 32'd1);
        br_taken = 1'b0; stall_flag = 1'b0;
        push(32'h200);
        tick(); check_eq("addr204", bus.imem_addr, 32'h204);

        // pc wraps at the top of the address space
        br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        tick(); check_eq("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        br_taken = 1'b0;
        push(32'hFFFF_FFFC); push(32'h0);
        tick(); check_eq("wrap_zero", bus.imem_addr, 32'h0);
        tick(); check_eq("wrap_four", bus.imem_addr, 32'h4);

        // reset while in DROP
        ready_drv = 1'b0; br_taken = 1'b1; br_target = 32'h300;
        tick(); check_eq("drop_b_addr", bus.imem_addr, 32'h4);
        br_taken = 1'b0; rst_n = 1'b0;
        #1; check_eq("rstdrop_req", {31'b0, bus.imem_req}, 32'd0);
        tick();
        check_eq("rstdrop_pc_out", pc_out, 32'h0);
        check_eq("rstdrop_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("rstdrop_inst", inst_out, C_NOP);
`ifdef FETCH_PERF_CNT_EN
        check_eq("rst_perf_fetch", perf_fetch_cnt, 32'h0);
        check_eq("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif
        rst_n = 1'b1; ready_drv = 1'b1;
        #1;
        check_eq("rel2_addr", bus.imem_addr, 32'h0);
        check_eq("rel2_req", {31'b0, bus.imem_req}, 32'd1);
        push(32'h0);
        tick(); check_eq("rel2_addr4", bus.imem_addr, 32'h4);
        ready_drv = 1'b0;
        tick(); tick();
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
